// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes IDLE -> ACCESS -> DONE; every output is registered.
module data_mem_arbiter #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*DATA_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  busy,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;

  logic                win;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_inr;

  // With both ports requesting, the one not served last wins.
  always_comb begin
    win       = (req == 2'b11) ? ~last_q : req[1];
    sel_we    = win ? we[1] : we[0];
    sel_addr  = win ? addr[2*DATA_W-1:DATA_W] : addr[DATA_W-1:0];
    sel_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    sel_inr   = sel_addr < DATA_W'(DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    oor_d       = oor_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StAccess;
          last_d      = win;
          win_d       = win;
          we_d        = sel_we;
          oor_d       = ~sel_inr;
          gnt_d       = win ? 2'b10 : 2'b01;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_read_d  = sel_inr & ~sel_we;
          mem_write_d = sel_inr & sel_we;
        end
      end
      StAccess: begin
        state_d  = StDone;
        rvalid_d = win_q ? 2'b10 : 2'b01;
        err_d    = oor_q;
        // Memory presents read data on the negedge of the strobe cycle.
        if (oor_q) begin
          rdata_d = '0;
        end else if (!we_q) begin
          rdata_d = mem_rdata;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule
